// File: rtl/demux_sched_pkg.sv
// demux_sched_pkg -- shared constants and types for the 1-to-4 dispatch
// scheduler.
//   NUM_OUT : number of destinations
//   SEL_W   : width of the destination index
//   CNT_W   : width of each per-destination dispatch counter
//   state_t : scheduler FSM state (IDLE = nothing held, DISPATCH = item offered)
//   onehot(): destination index -> one-hot valid vector
package demux_sched_pkg;

  localparam int NUM_OUT = 4;
  localparam int SEL_W   = 2;
  localparam int CNT_W   = 8;

  typedef enum logic {
    IDLE     = 1'b0,
    DISPATCH = 1'b1
  } state_t;

  function automatic logic [NUM_OUT-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_OUT-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/demux_sched_if.sv
// demux_sched_if -- handshake bundle between the upstream producer, the
// scheduler and the four destinations.
//   en, mask, in_valid, in_data, out_ready : driven by the environment
//   in_ready, sel, out_valid, out_data     : driven by the scheduler
// Modports: master = environment side, slave = scheduler side.
interface demux_sched_if #(
  parameter int DATA_W = 8
);
  import demux_sched_pkg::*;

  logic                 en;
  logic [NUM_OUT-1:0]   mask;
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_W-1:0]    in_data;
  logic [SEL_W-1:0]     sel;
  logic [NUM_OUT-1:0]   out_valid;
  logic [NUM_OUT-1:0]   out_ready;
  logic [DATA_W-1:0]    out_data;

  modport master (
    output en, mask, in_valid, in_data, out_ready,
    input  in_ready, sel, out_valid, out_data
  );

  modport slave (
    input  en, mask, in_valid, in_data, out_ready,
    output in_ready, sel, out_valid, out_data
  );

endinterface

// File: rtl/rr_pick4.sv
// rr_pick4 -- combinational round-robin picker over four requesters.
//   mask  [3:0] : eligible destinations
//   ptr   [1:0] : first index to consider; scan goes ptr, ptr+1, ... mod 4
//   grant [1:0] : first eligible index found (0 when none)
//   any         : at least one destination eligible
module rr_pick4
  import demux_sched_pkg::*;
(
  input  logic [NUM_OUT-1:0] mask,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   grant,
  output logic               any
);

  logic [SEL_W-1:0] idx;

  // Scan from the farthest offset back to offset 0 so the nearest eligible
  // index after ptr is the one left in grant.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |mask;
    for (int off = NUM_OUT - 1; off >= 0; off--) begin
      idx = ptr + SEL_W'(off);
      if (mask[idx]) begin
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/demux_sched_1to4.sv
// demux_sched_1to4 -- accepts one item at a time from upstream, picks a
// destination round-robin among the enabled ones, and holds the item on the
// shared out_data bus until the chosen destination takes it.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   bus      : demux_sched_if.slave (en, mask, in_valid/in_ready/in_data,
//              sel, out_valid/out_ready/out_data)
//   disp_cnt : per-destination 8-bit saturating handshake counters, only
//              present when DEMUX_SCHED_STATS_EN is defined
module demux_sched_1to4
  import demux_sched_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  demux_sched_if.slave               bus
`ifdef DEMUX_SCHED_STATS_EN
  ,
  output logic [NUM_OUT*CNT_W-1:0]   disp_cnt
`endif
);

  state_t              state_reg, state_next;
  logic [SEL_W-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [SEL_W-1:0]    sel_reg, sel_next;
  logic [DATA_W-1:0]   data_reg, data_next;

  logic [SEL_W-1:0]    grant;
  logic                any;
  logic                accept;
  logic                done;

  rr_pick4 u_pick (
    .mask  (bus.mask),
    .ptr   (rr_ptr_reg),
    .grant (grant),
    .any   (any)
  );

  // en/mask only gate acceptance; once an item is held they are ignored so
  // the offered item stays stable until its destination takes it.
  assign bus.in_ready  = (state_reg == IDLE) && bus.en && any;
  assign accept        = bus.in_valid && bus.in_ready;
  assign done          = (state_reg == DISPATCH) && bus.out_ready[sel_reg];
  assign bus.out_valid = (state_reg == DISPATCH) ? onehot(sel_reg) : '0;
  assign bus.sel       = sel_reg;
  assign bus.out_data  = data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      sel_reg    <= '0;
      data_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      sel_reg    <= sel_next;
      data_reg   <= data_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    sel_next    = sel_reg;
    data_next   = data_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = DISPATCH;
          sel_next   = grant;
          data_next  = bus.in_data;
        end
      end
      DISPATCH: begin
        // No accept in this cycle: in_ready is low outside IDLE, which caps
        // throughput at one item per two cycles.
        if (done) begin
          state_next  = IDLE;
          rr_ptr_next = sel_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef DEMUX_SCHED_STATS_EN
  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg <= '0;
      end else if (done && (sel_reg == SEL_W'(gi)) && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end

    assign disp_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
  end
`endif

endmodule

// File: tb/tb_demux_sched_1to4.sv
// tb_demux_sched_1to4 -- directed self-checking bench for demux_sched_1to4.
// Covers round-robin order, masked scheduling, hold stability under back
// pressure, blocked acceptance, reset during dispatch and (when
// DEMUX_SCHED_STATS_EN is defined) counter saturation.
module tb_demux_sched_1to4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  demux_sched_if #(.DATA_W(8)) bus ();

`ifdef DEMUX_SCHED_STATS_EN
  logic [31:0] disp_cnt;
`endif

  demux_sched_1to4 #(.DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave)
`ifdef DEMUX_SCHED_STATS_EN
    ,
    .disp_cnt (disp_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_sel", 32'(bus.sel), 32'h0);
    check("rst_out_data", 32'(bus.out_data), 32'h0);
    rst = 1'b0;
    #1;
  endtask

  // Offer one item with all out_ready high: expect acceptance now, a one-hot
  // valid at exp_sel right after the accepting edge, and IDLE one edge later.
  task automatic send_item(input logic [7:0] d, input logic [1:0] exp_sel);
    logic [3:0] exp_v;
    exp_v = 4'b0001 << exp_sel;
    bus.out_ready = 4'b1111;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    #1;
    check("pre_in_ready", 32'(bus.in_ready), 32'h1);
    check("pre_out_valid", 32'(bus.out_valid), 32'h0);
    tick();
    bus.in_valid = 1'b0;
    #1;
    check("out_valid", 32'(bus.out_valid), 32'(exp_v));
    check("sel", 32'(bus.sel), 32'(exp_sel));
    check("out_data", 32'(bus.out_data), 32'(d));
    check("busy_in_ready", 32'(bus.in_ready), 32'h0);
    $display("item %02h -> out %0d", d, exp_sel);
    tick();
    check("post_out_valid", 32'(bus.out_valid), 32'h0);
    check("post_sel_hold", 32'(bus.sel), 32'(exp_sel));
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst           = 1'b1;
    bus.en        = 1'b0;
    bus.mask      = 4'b0000;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 4'b0000;
    tick();
    do_reset();
    check("rst_in_ready", 32'(bus.in_ready), 32'h0);

    // Round robin over all four destinations.
    bus.en   = 1'b1;
    bus.mask = 4'b1111;
    send_item(8'hA1, 2'd0);
    send_item(8'hB2, 2'd1);
    send_item(8'hC3, 2'd2);
    send_item(8'hD4, 2'd3);
    send_item(8'hE5, 2'd0);

    // Only destinations 0 and 2 eligible.
    do_reset();
    bus.mask = 4'b0101;
    send_item(8'h10, 2'd0);
    send_item(8'h11, 2'd2);
    send_item(8'h12, 2'd0);
    send_item(8'h13, 2'd2);

    // Back pressure: rr_ptr is 3, item goes to 3 and is held while en/mask
    // toggle and the non-selected ready bits are high.
    bus.mask      = 4'b1111;
    bus.out_ready = 4'b0000;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h5A;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0111;
    for (int i = 0; i < 5; i++) begin
      bus.en   = ~bus.en;
      bus.mask = (i % 2 == 0) ? 4'b0000 : 4'b0011;
      #1;
      check("hold_out_valid", 32'(bus.out_valid), 32'h8);
      check("hold_sel", 32'(bus.sel), 32'h3);
      check("hold_out_data", 32'(bus.out_data), 32'h5A);
      check("hold_in_ready", 32'(bus.in_ready), 32'h0);
      tick();
    end
    bus.out_ready = 4'b1000;
    tick();
    check("hold_release", 32'(bus.out_valid), 32'h0);
    $display("held item 5a released at out 3");
    bus.en   = 1'b1;
    bus.mask = 4'b1111;

    // Blocked acceptance must not move rr_ptr (currently 1 after this item).
    send_item(8'h21, 2'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    bus.mask     = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mask0_in_ready", 32'(bus.in_ready), 32'h0);
      tick();
      check("mask0_out_valid", 32'(bus.out_valid), 32'h0);
    end
    bus.mask = 4'b1111;
    bus.en   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("en0_in_ready", 32'(bus.in_ready), 32'h0);
      tick();
      check("en0_out_valid", 32'(bus.out_valid), 32'h0);
    end
    bus.in_valid = 1'b0;
    bus.en       = 1'b1;
    $display("blocked phase done, rr_ptr expected 1");
    send_item(8'h22, 2'd1);

    // Reset while an item is held at destination 2.
    bus.out_ready = 4'b0000;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h99;
    tick();
    bus.in_valid = 1'b0;
    #1;
    check("pre_rst_out_valid", 32'(bus.out_valid), 32'h4);
    do_reset();
    send_item(8'h33, 2'd0);

`ifdef DEMUX_SCHED_STATS_EN
    do_reset();
    check("cnt_reset", disp_cnt, 32'h0);
    bus.mask = 4'b0010;
    for (int i = 0; i < 300; i++) begin
      bus.out_ready = 4'b0010;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'(i);
      tick();
      bus.in_valid = 1'b0;
      tick();
      if (i == 0) check("cnt_one", disp_cnt, 32'h0000_0100);
    end
    check("cnt_sat", disp_cnt, 32'h0000_FF00);
    $display("300 handshakes to out 1 done");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/demux_sched_1to4.md
DEMUX_SCHED_1TO4 -- requirements
Module: demux_sched_1to4

Interface
REQ-001 SHALL have parameter: DATA_W, 8, payload width in bits.
REQ-002 SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-003 SHALL have these ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  global enable
- mask  input  4  destination enable, bit i = output i eligible
- in_valid  input  1  upstream item valid
- in_ready  output  1  block can accept an item
- in_data  input  DATA_W  upstream payload
- sel  output  2  demux select, drives the 1-to-4 demux S input
- out_valid  output  4  one-hot valid toward the selected destination
- out_ready  input  4  per-destination ready
- out_data  output  DATA_W  held payload, shared by all destinations

Function
REQ-004 SHALL implement a 2-state FSM: IDLE (no item held) and DISPATCH (item held and offered).
REQ-005 in_ready SHALL be 1 only when state==IDLE, en==1 and mask!=0 (combinational).
REQ-006 On in_valid && in_ready in IDLE, SHALL:
- latch in_data into out_data;
- set sel to the first mask bit found scanning rr_ptr, rr_ptr+1, ... modulo 4;
- go to DISPATCH.
REQ-007 In DISPATCH, out_valid SHALL be one-hot at bit sel; in IDLE, out_valid SHALL be 4'b0000.
REQ-008 Latency: an item accepted in cycle N SHALL appear on out_valid in cycle N+1.
REQ-009 On out_valid[sel] && out_ready[sel], SHALL return to IDLE and set rr_ptr <= sel+1, wrapping 3->0.
REQ-010 out_ready bits other than sel SHALL be ignored.
REQ-011 Once asserted, out_valid, sel and out_data SHALL stay stable until the handshake completes, even if en or mask change.
REQ-012 With mask==0 or en==0 in IDLE, SHALL accept nothing, and rr_ptr SHALL be unchanged.
REQ-013 Peak throughput SHALL be one item per 2 cycles; no new item is accepted in the cycle a handshake completes.
REQ-014 sel SHALL hold its last value while in IDLE.

Reset
REQ-015 On rst=1 at a clock edge, SHALL set state=IDLE, rr_ptr=0, sel=0, out_data=0, out_valid=0 and, when compiled in, all counters=0.
REQ-016 Reset asserted during DISPATCH SHALL drop the held item with no handshake.
REQ-017 rst SHALL take priority over all other inputs in the same cycle.

Configuration
REQ-018 Macro DEMUX_SCHED_STATS_EN, when defined, SHALL add output port disp_cnt (32 bits):
- four 8-bit saturating counters, counter i in bits [8i+7:8i];
- counter i increments on each completed handshake at output i;
- counters saturate at 255.
REQ-019 Without DEMUX_SCHED_STATS_EN, the disp_cnt port and the counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-020 SHALL place in shared package demux_sched_pkg:
- NUM_OUT=4, SEL_W=2, CNT_W=8;
- the FSM state enum (IDLE, DISPATCH).
REQ-021 SHALL use one sub-module rr_pick4: combinational, inputs mask[3:0] and ptr[1:0], outputs grant index[1:0] and any.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Reset, then mask=1111, en=1, items A,B,C,D,E with all out_ready=1 -> sel sequence 0,1,2,3,0; each out_valid exactly one cycle after its accept.
- mask=0101, 4 items -> sel sequence 0,2,0,2; out_valid never 0010 or 1000.
- Item held with out_ready[sel]=0 for 5 cycles, en and mask toggled meanwhile -> out_valid, sel and out_data stable; in_ready=0 throughout.
- mask=0000 or en=0 with in_valid=1 -> in_ready=0; rr_ptr unchanged.
- rst pulsed during DISPATCH -> next cycle out_valid=0, sel=0; next item goes to output 0.
- STATS_EN build, 300 handshakes to output 1 -> disp_cnt[15:8]=255; other counters 0.
